// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared encodings, state type and helpers for dmem_access_ctrl
// Optional feature macro used by the controller: MEM_MISALIGN_EXC_EN.
package dmem_access_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DMEM_WORDS = 1024;
  localparam int DMEM_AW    = $clog2(DMEM_WORDS);

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RD_ISSUE = 3'd1;
  localparam state_t ST_RD_DATA  = 3'd2;
  localparam state_t ST_WR       = 3'd3;
  localparam state_t ST_EXC      = 3'd4;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  addr_lo;
    logic [31:0] wr_data;
  } req_t;

  // Encoding 11 is an alias for a full word.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SZ_WORD : size;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [1:0] sz;
    sz = norm_size(size);
    return ((sz == SZ_HALF) && addr_lo[0]) || ((sz == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_mem_lane_align.sv
// rtl/dmem_access_ctrl_mem_lane_align.sv - combinational load extract/extend and store lane merge
// Little-endian lanes; half-words use addr_lo_i[1] only, so an odd half address is folded down.
module mem_lane_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rd_word_i,
  input  logic [31:0] wr_data_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_word_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rd_word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel  = rd_word_i[{addr_lo_i[1], 4'b0000} +: 16];
    ld_data_o = rd_word_i;
    st_word_o = rd_word_i;
    case (norm_size(size_i))
      SZ_BYTE: begin
        ld_data_o = {{24{sgn_i & byte_sel[7]}}, byte_sel};
        st_word_o[{addr_lo_i, 3'b000} +: 8] = wr_data_i[7:0];
      end
      SZ_HALF: begin
        ld_data_o = {{16{sgn_i & half_sel[15]}}, half_sel};
        st_word_o[{addr_lo_i[1], 4'b0000} +: 16] = wr_data_i[15:0];
      end
      default: begin
        ld_data_o = rd_word_i;
        st_word_o = wr_data_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage load/store controller with read-modify-write for sub-word stores
// Define MEM_MISALIGN_EXC_EN to trap misaligned half/word accesses and expose RspExc.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWrData,
  output logic        RspValid,
  output logic [31:0] RspData,
  output logic [31:0] DmemAddr,
  output logic        DmemWrite,
  output logic [31:0] DmemWrData,
  input  logic [31:0] DmemRdData
`ifdef MEM_MISALIGN_EXC_EN
  ,
  output logic        RspExc
`endif
);

  state_t      state_q, state_d;
  req_t        req_q;
  logic [31:0] dmem_addr_q;
  logic [31:0] dmem_wr_data_q, dmem_wr_data_d;
  logic        dmem_write_q;
  logic [31:0] rsp_data_q;
  logic        accept, bad_align, load_done;
  logic [31:0] ld_data, st_word;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^ReqAddr[31:DMEM_AW+2];

  assign ReqReady  = (state_q == ST_IDLE);
  assign accept    = ReqValid & ReqReady;
  assign load_done = (state_q == ST_RD_DATA) && !req_q.write;

`ifdef MEM_MISALIGN_EXC_EN
  assign bad_align = is_misaligned(ReqSize, ReqAddr[1:0]);
  assign RspExc    = (state_q == ST_EXC);
`else
  assign bad_align = 1'b0;
`endif

  mem_lane_align u_lane_align (
    .size_i    (req_q.size),
    .sgn_i     (req_q.sgn),
    .addr_lo_i (req_q.addr_lo),
    .rd_word_i (DmemRdData),
    .wr_data_i (req_q.wr_data),
    .ld_data_o (ld_data),
    .st_word_o (st_word)
  );

  always_comb begin
    state_d        = state_q;
    dmem_wr_data_d = dmem_wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bad_align) begin
            state_d = ST_EXC;
          end else if (ReqWrite && (norm_size(ReqSize) == SZ_WORD)) begin
            state_d        = ST_WR;
            dmem_wr_data_d = ReqWrData;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        // Sub-word stores merge into the word just read back.
        if (req_q.write) begin
          state_d        = ST_WR;
          dmem_wr_data_d = st_word;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q        <= ST_IDLE;
      req_q          <= '0;
      dmem_addr_q    <= '0;
      dmem_wr_data_q <= '0;
      dmem_write_q   <= 1'b0;
      rsp_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      dmem_write_q   <= (state_d == ST_WR);
      dmem_wr_data_q <= dmem_wr_data_d;
      if (accept) begin
        req_q <= '{write: ReqWrite, size: ReqSize, sgn: ReqSigned,
                   addr_lo: ReqAddr[1:0], wr_data: ReqWrData};
        dmem_addr_q <= 32'(ReqAddr[DMEM_AW+1:2]);
      end
      if (load_done) begin
        rsp_data_q <= ld_data;
      end
    end
  end

  assign DmemAddr   = dmem_addr_q;
  assign DmemWrite  = dmem_write_q;
  assign DmemWrData = dmem_wr_data_q;
  assign RspValid   = load_done || (state_q == ST_WR) || (state_q == ST_EXC);
  assign RspData    = load_done ? ld_data : rsp_data_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - scoreboard bench for dmem_access_ctrl (honours MEM_MISALIGN_EXC_EN)
module tb_dmem_access_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqWrite = 1'b0;
  logic [1:0]  ReqSize = 2'b00;
  logic        ReqSigned = 1'b0;
  logic [31:0] ReqAddr = '0;
  logic [31:0] ReqWrData = '0;
  logic        ReqReady, RspValid, DmemWrite;
  logic [31:0] RspData, DmemAddr, DmemWrData;
  logic [31:0] DmemRdData;
`ifdef MEM_MISALIGN_EXC_EN
  logic        RspExc;
`endif

  always #5 Clk = ~Clk;

  dmem_access_ctrl dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqWrite   (ReqWrite),
    .ReqSize    (ReqSize),
    .ReqSigned  (ReqSigned),
    .ReqAddr    (ReqAddr),
    .ReqWrData  (ReqWrData),
    .RspValid   (RspValid),
    .RspData    (RspData),
    .DmemAddr   (DmemAddr),
    .DmemWrite  (DmemWrite),
    .DmemWrData (DmemWrData),
    .DmemRdData (DmemRdData)
`ifdef MEM_MISALIGN_EXC_EN
    ,
    .RspExc     (RspExc)
`endif
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) + 32'd1) * 32'h9E3779B9;
  endfunction

  logic [31:0] mem [0:1023];
  logic        mem_ready = 1'b0;
  int          cyc = 0;

  always @(posedge Clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (DmemWrite) begin
      mem[DmemAddr[9:0]] <= DmemWrData;
    end
    DmemRdData <= mem[DmemAddr[9:0]];
    cyc <= cyc + 1;
  end

  typedef struct { int cyc; logic [31:0] data; logic exc; } rsp_t;
  typedef struct { int cyc; logic [31:0] addr; logic [31:0] data; } wr_t;

  rsp_t        rsp_q[$];
  wr_t         wr_q[$];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] last_load;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    rsp_t r;
    wr_t  w;
    forever begin
      @(negedge Clk);
      if (Rst_n && RspValid) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(r.cyc));
          check("rsp_data", RspData, r.data);
`ifdef MEM_MISALIGN_EXC_EN
          check("rsp_exc", 32'(RspExc), 32'(r.exc));
`endif
        end
      end
      if (DmemWrite) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", DmemAddr, 32'hFFFFFFFF);
        end else begin
          w = wr_q.pop_front();
          check("wr_cycle", 32'(cyc), 32'(w.cyc));
          check("wr_addr", DmemAddr, w.addr);
          check("wr_data", DmemWrData, w.data);
        end
      end
    end
  endtask

  // Reference: serial accesses applied to ref_mem with plain shifts and masks.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] data, input bit abort);
    int          waited, idx, nsz, k, h, lat;
    logic [31:0] w, v, m, mask;
    logic        exc;
    rsp_t        r;
    wr_t         wq;
    waited = 0;
    while (!ReqReady && waited < 20) begin
      @(negedge Clk);
      waited++;
    end
    if (!ReqReady) begin
      check("req_ready_timeout", 32'(ReqReady), 32'd1);
      return;
    end
    idx = int'(addr[11:2]);
    nsz = (sz == 2'b11) ? 2 : int'(sz);
    k   = int'(addr[1:0]);
    h   = int'(addr[1]);
    exc = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
    exc = (nsz == 1 && addr[0]) || (nsz == 2 && addr[1:0] != 2'b00);
`endif
    w = ref_mem[idx];
    v = last_load;
    if (exc) begin
      lat = 0;
    end else if (!wr) begin
      lat = 1;
      if (nsz == 0) begin
        v = (w >> (8 * k)) & 32'hFF;
        if (sg && v[7]) v = v | 32'hFFFFFF00;
      end else if (nsz == 1) begin
        v = (w >> (16 * h)) & 32'hFFFF;
        if (sg && v[15]) v = v | 32'hFFFF0000;
      end else begin
        v = w;
      end
    end else begin
      if (nsz == 2) begin
        lat = 0;
        m   = data;
      end else begin
        lat  = 2;
        mask = (nsz == 0) ? (32'hFF << (8 * k)) : (32'hFFFF << (16 * h));
        m    = (w & ~mask) | (((nsz == 0) ? (data & 32'hFF) : (data & 32'hFFFF))
                              << ((nsz == 0) ? 8 * k : 16 * h));
      end
      if (!abort) begin
        ref_mem[idx] = m;
        wq.cyc = cyc + 1 + lat; wq.addr = 32'(idx); wq.data = m;
        wr_q.push_back(wq);
      end
    end
    if (!abort) begin
      if (!wr && !exc) last_load = v;
      r.cyc = cyc + 1 + lat; r.data = last_load; r.exc = exc;
      rsp_q.push_back(r);
    end
    ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqSigned = sg;
    ReqAddr = addr; ReqWrData = data;
    @(posedge Clk);
    @(negedge Clk);
    ReqValid  = 1'b0;
    ReqWrite  = 1'($urandom());
    ReqSize   = 2'($urandom());
    ReqSigned = 1'($urandom());
    ReqAddr   = $urandom();
    ReqWrData = $urandom();
  endtask

  initial begin
    logic [31:0] a;
    int          drain;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    last_load = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rst_req_ready", 32'(ReqReady), 32'd1);
    check("rst_rsp_valid", 32'(RspValid), 32'd0);
    check("rst_dmem_write", 32'(DmemWrite), 32'd0);
    check("rst_dmem_addr", DmemAddr, 32'd0);
    check("rst_dmem_wr_data", DmemWrData, 32'd0);
    check("rst_rsp_data", RspData, 32'd0);
`ifdef MEM_MISALIGN_EXC_EN
    check("rst_rsp_exc", 32'(RspExc), 32'd0);
`endif

    issue(1, 2'b10, 0, 32'h14, 32'h11223344, 0);
    issue(0, 2'b10, 0, 32'h14, 32'h0, 0);
    issue(0, 2'b00, 1, 32'h17, 32'h0, 0);
    issue(1, 2'b10, 0, 32'h14, 32'h1122F344, 0);
    issue(0, 2'b01, 1, 32'h14, 32'h0, 0);
    issue(1, 2'b10, 0, 32'h14, 32'h112233F4, 0);
    issue(0, 2'b00, 0, 32'h14, 32'h0, 0);
    issue(1, 2'b10, 0, 32'h14, 32'h11223344, 0);
    issue(1, 2'b00, 0, 32'h15, 32'hFFFFFFAB, 0);
    issue(0, 2'b10, 0, 32'h14, 32'h0, 0);
    issue(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 0);
    issue(0, 2'b10, 0, 32'h20, 32'h0, 0);
    issue(0, 2'b10, 0, 32'h22, 32'h0, 0);
    issue(0, 2'b11, 1, 32'h16, 32'h0, 0);

    // Reset lands on the edge leaving RD_DATA of a half store.
    issue(1, 2'b01, 0, 32'h14, 32'h0000BEEF, 1);
    @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    check("abort_dmem_write", 32'(DmemWrite), 32'd0);
    check("abort_rsp_valid", 32'(RspValid), 32'd0);
    check("abort_req_ready", 32'(ReqReady), 32'd1);
    Rst_n = 1'b1;
    last_load = '0;
    @(negedge Clk);
    check("abort_no_late_write", 32'(DmemWrite), 32'd0);
    issue(0, 2'b10, 0, 32'h14, 32'h0, 0);

    for (int n = 0; n < 300; n++) begin
      a = $urandom();
      a[11:6] = '0;
      issue(1'($urandom()), 2'($urandom_range(0, 3)), 1'($urandom()), a, $urandom(), 0);
    end

    drain = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && drain < 20) begin
      @(negedge Clk);
      drain++;
    end
    check("drain_pending", 32'(rsp_q.size() + wr_q.size()), 32'd0);
    repeat (2) @(negedge Clk);
    for (int i = 0; i < 16; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 SHALL have ports: Clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: Rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: ReqValid  input  1  MEM-stage access request.
REQ-004 SHALL have ports: ReqReady  output  1  request accepted when ReqValid&ReqReady at a rising edge.
REQ-005 SHALL have ports: ReqWrite  input  1  1=store, 0=load.
REQ-006 SHALL have ports: ReqSize  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-007 SHALL have ports: ReqSigned  input  1  sign-extend sub-word loads.
REQ-008 SHALL have ports: ReqAddr  input  32  byte address; ReqWrData  input  32  store data, right-aligned.
REQ-009 SHALL have ports: RspValid  output  1  one-cycle completion pulse; RspData  output  32  load result.
REQ-010 SHALL have ports: DmemAddr  output  32  word index; DmemWrite  output  1; DmemWrData  output  32; DmemRdData  input  32 (memory registers read data one edge after address).
REQ-011 SHALL have port RspExc  output  1, present only under MEM_MISALIGN_EXC_EN.

Function
REQ-012 Byte lanes SHALL be little-endian: byte k = bits [8k+7:8k], k=ReqAddr[1:0].
REQ-013 DmemAddr SHALL be registered, = {22'b0, ReqAddr[11:2]} latched at acceptance.
REQ-014 DmemWrite, DmemWrData SHALL be registered outputs.
REQ-015 FSM states SHALL be IDLE, RD_ISSUE, RD_DATA, WR, EXC; ReqReady=1 only in IDLE.
REQ-016 Load: IDLE -accept-> RD_ISSUE -> RD_DATA -> IDLE; RspValid=1 and RspData valid in RD_DATA (2 cycles after acceptance edge).
REQ-017 Load extraction: byte/half lane selected by ReqAddr[1:0]/ReqAddr[1], zero- or sign-extended per ReqSigned; word unchanged.
REQ-018 Word store: IDLE -accept-> WR; DmemWrite=1 with DmemWrData=ReqWrData for exactly one cycle; RspValid=1 in WR.
REQ-019 Sub-word store: IDLE -> RD_ISSUE -> RD_DATA -> WR (read-modify-write); WR writes DmemRdData with only the addressed lane(s) replaced; RspValid=1 in WR only.
REQ-020 DmemWrite SHALL be 0 in every state except WR.
REQ-021 Requests while ReqReady=0 SHALL be ignored; request fields SHALL be latched at acceptance.
REQ-022 Back-to-back: accept SHALL be possible in the cycle after RspValid (IDLE reached).
REQ-023 RspData SHALL hold last load result outside RD_DATA; RspValid=0 outside completion states.

Reset
REQ-024 On rising edge with Rst_n=0: state=IDLE, DmemWrite=0, DmemAddr=0, DmemWrData=0, RspValid=0, RspData=0, RspExc=0.
REQ-025 Reset mid-operation SHALL abandon the access with no memory write and no RspValid; a pending WR SHALL not write.

Configuration
REQ-026 Macro MEM_MISALIGN_EXC_EN defined: half with ReqAddr[0]=1 or word with ReqAddr[1:0]!=0 SHALL go IDLE->EXC->IDLE, RspValid=1 and RspExc=1 in EXC, no memory write.
REQ-027 Macro undefined: no RspExc port; half ignores ReqAddr[0], word ignores ReqAddr[1:0]; access proceeds normally.

Structure
REQ-028 Shared package SHALL hold size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state type, DMEM_WORDS=1024.
REQ-029 One sub-module mem_lane_align SHALL implement combinational load extract/extend and store lane merge.

Verification
REQ-030 Word[5]=0x11223344; load word addr 0x14 -> RspValid 2 cycles after accept, RspData=0x11223344.
REQ-031 Same word; lb signed addr 0x17 -> 0x00000011; lh signed addr 0x14 with word 0x1122F344 -> 0xFFFFF344; lbu addr 0x14 with 0x...F4 -> 0x000000F4.
REQ-032 Word[5]=0x11223344; sb 0xAB addr 0x15 -> one DmemWrite pulse, word becomes 0x1122AB44, RspValid in WR only.
REQ-033 sw 0xDEADBEEF addr 0x20 -> DmemWrite 1 cycle after accept, DmemAddr=8, then lw 0x20 -> 0xDEADBEEF.
REQ-034 Rst_n=0 during RD_DATA of sh -> no DmemWrite, RspValid=0, ReqReady=1 next cycle.
REQ-035 With MEM_MISALIGN_EXC_EN: lw addr 0x22 -> RspValid=RspExc=1 one cycle after accept, memory unchanged; without macro -> reads word 8.
